// File: rtl/vga_pkg.sv
// vga_pkg: shared raster constants for the 640x480@60 display path.
// Sprite blocks import this package so that their col/row inputs and pixel
// outputs are sized identically to the scan generator.
//   COORD_W     width of col/row scan coordinates
//   RGB_W       width of a packed 4:4:4 pixel
//   DEF_*       default 640x480@60 timing (pixels / lines)
//   in_window() half-open range test used for the sync windows
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 12;

  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_ANIM_FRAMES = 30;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_H_TOT  = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_V_TOT  = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // True when lo <= cnt < hi.
  function automatic logic in_window(input logic [COORD_W-1:0] cnt,
                                     input int lo, input int hi);
    int c;
    c = int'(cnt);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/vga_scan_anim_toggle.sv
// anim_toggle: divides a frame-rate pulse into a slow square wave that
// sprite animations use to flip between frames.
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   frame_tick_i  one-clk pulse per frame
//   toggle_clk_o  inverts every ANIM_FRAMES ticks (period 2*ANIM_FRAMES frames)
module anim_toggle #(
  parameter int ANIM_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick_i,
  output logic toggle_clk_o
);

  // One bit minimum so ANIM_FRAMES==1 still elaborates a legal counter.
  localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [AW-1:0] CNT_LAST = AW'(ANIM_FRAMES - 1);

  logic [AW-1:0] anim_cnt_q, anim_cnt_d;
  logic          toggle_q, toggle_d;

  always_comb begin
    anim_cnt_d = anim_cnt_q;
    toggle_d   = toggle_q;
    if (frame_tick_i) begin
      if (anim_cnt_q == CNT_LAST) begin
        anim_cnt_d = '0;
        toggle_d   = ~toggle_q;
      end else begin
        anim_cnt_d = anim_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anim_cnt_q <= '0;
      toggle_q   <= 1'b0;
    end else begin
      anim_cnt_q <= anim_cnt_d;
      toggle_q   <= toggle_d;
    end
  end

  assign toggle_clk_o = toggle_q;

endmodule

// File: rtl/vga_scan.sv
// vga_scan: raster timing generator and one-pixel output stage.
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   col, row    scan coordinates handed to the sprite blocks
//   video_on    col/row lie inside the visible area (combinational)
//   rgb_in      composited pixel for the current col/row
//   hs, vs      active-low syncs, registered, aligned with rgb
//   rgb         registered pixel to the DAC, blanked outside the visible area
//   frame_tick  one-clk pulse on the last pixel of each frame
//   toggle_clk  animation square wave, period 2*ANIM_FRAMES frames
// CLK_DIV must be 2..15; each of H and V totals must be <= 1024.
module vga_scan
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_VIS       = DEF_H_VIS,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_VIS       = DEF_V_VIS,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int ANIM_FRAMES = DEF_ANIM_FRAMES
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               video_on,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic               hs,
  output logic               vs,
  output logic [RGB_W-1:0]   rgb,
  output logic               frame_tick,
  output logic               toggle_clk
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int HS_LO = H_VIS + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC;
  localparam int VS_LO = V_VIS + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC;

  localparam logic [3:0]         DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] H_VIS_C  = COORD_W'(H_VIS);
  localparam logic [COORD_W-1:0] V_VIS_C  = COORD_W'(V_VIS);

  logic [3:0]         div_cnt_q, div_cnt_d;
  logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
  logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;

  logic pix_en;
  logic h_last, v_last;
  logic line_end;
  logic hs_raw, vs_raw;
  logic vis;

  assign pix_en   = (div_cnt_q == DIV_LAST);
  assign h_last   = (h_cnt_q == H_LAST);
  assign v_last   = (v_cnt_q == V_LAST);
  assign line_end = pix_en & h_last;
  assign vis      = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);

  assign hs_raw = ~in_window(h_cnt_q, HS_LO, HS_HI);
  assign vs_raw = ~in_window(v_cnt_q, VS_LO, VS_HI);

  always_comb begin
    div_cnt_d = div_cnt_q + 4'd1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    rgb_d     = rgb_q;

    if (pix_en) begin
      div_cnt_d = '0;
      h_cnt_d   = h_last ? '0 : h_cnt_q + 1'b1;
      // Sync and pixel are captured from the coordinate being retired, so
      // they leave one pixel behind col/row and stay mutually aligned.
      // rgb_in has had CLK_DIV-1 clocks to settle since col/row changed.
      hs_d      = hs_raw;
      vs_d      = vs_raw;
      rgb_d     = vis ? rgb_in : '0;
    end

    if (line_end) begin
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rgb_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      rgb_q     <= rgb_d;
    end
  end

  // Combinational pulse: the last pixel's pix_en cycle. pix_en is low
  // throughout reset (div_cnt held at 0, CLK_DIV >= 2), so it reads 0 there.
  assign frame_tick = line_end & v_last;

  assign col      = h_cnt_q;
  assign row      = v_cnt_q;
  assign video_on = vis;
  assign hs       = hs_q;
  assign vs       = vs_q;
  assign rgb      = rgb_q;

  anim_toggle #(
    .ANIM_FRAMES (ANIM_FRAMES)
  ) u_anim_toggle (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick_i (frame_tick),
    .toggle_clk_o (toggle_clk)
  );

endmodule

// File: tb/tb_vga_scan.sv
// Bench for vga_scan using a reduced raster (48x19 totals) so several whole
// frames fit in a short run. Instance A: CLK_DIV=4, ANIM_FRAMES=2, rgb_in
// = {row[3:0],col[7:0]}. Instance B: CLK_DIV=2, ANIM_FRAMES=1, rgb_in from a
// 1-clk-latency ROM holding a randomly seeded hash of col/row.
// The reference model derives every output from the number of clock edges
// since reset release: pixel index P = edges / CLK_DIV.
module tb_vga_scan;

  localparam int HV = 32, HF = 4, HSY = 6, HB = 6;
  localparam int VV = 12, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HV + HF + HSY + HB;   // 48
  localparam int VT = VV + VF + VSY + VB;   // 19
  localparam int FR = HT * VT;              // pixels per frame
  localparam int CDA = 4, CDB = 2;
  localparam int ANA = 2, ANB = 1;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;

  logic [9:0]  col_a, row_a, col_b, row_b;
  logic        vo_a, vo_b, hs_a, hs_b, vs_a, vs_b, ft_a, ft_b, tog_a, tog_b;
  logic [11:0] rgb_a, rgb_b, rgb_in_a, rom_b;

  int checks = 0;
  int failures = 0;
  int na = 0;
  int nb = 0;
  int seed_b = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(input bit hashed, input int c, input int r, input int s);
    logic [9:0] cc, rr;
    cc = c[9:0];
    rr = r[9:0];
    if (hashed) return 12'((c * 37) ^ (r * 113) ^ s);
    return {rr[3:0], cc[7:0]};
  endfunction

  function automatic bit exp_hs(input int p);
    int h;
    if (p == 0) return 1'b1;
    h = (p - 1) % HT;
    return !(h >= HV + HF && h < HV + HF + HSY);
  endfunction

  function automatic bit exp_vs(input int p);
    int v;
    if (p == 0) return 1'b1;
    v = ((p - 1) / HT) % VT;
    return !(v >= VV + VF && v < VV + VF + VSY);
  endfunction

  function automatic logic [11:0] exp_rgb(input int p, input bit hashed, input int s);
    int h, v;
    if (p == 0) return 12'h000;
    h = (p - 1) % HT;
    v = ((p - 1) / HT) % VT;
    if (h < HV && v < VV) return pat(hashed, h, v, s);
    return 12'h000;
  endfunction

  function automatic bit exp_ft(input int n, input int cd);
    return (n % cd == cd - 1) && ((n / cd) % FR == FR - 1);
  endfunction

  assign rgb_in_a = pat(1'b0, int'(col_a), int'(row_a), 0);

  always @(posedge clk) rom_b <= pat(1'b1, int'(col_b), int'(row_b), seed_b);

  always @(posedge clk or negedge rst_n_a)
    if (!rst_n_a) na <= 0; else na <= na + 1;

  always @(posedge clk or negedge rst_n_b)
    if (!rst_n_b) nb <= 0; else nb <= nb + 1;

  vga_scan #(
    .CLK_DIV(CDA), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .ANIM_FRAMES(ANA)
  ) dut_a (
    .clk(clk), .rst_n(rst_n_a), .col(col_a), .row(row_a), .video_on(vo_a),
    .rgb_in(rgb_in_a), .hs(hs_a), .vs(vs_a), .rgb(rgb_a),
    .frame_tick(ft_a), .toggle_clk(tog_a)
  );

  vga_scan #(
    .CLK_DIV(CDB), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .ANIM_FRAMES(ANB)
  ) dut_b (
    .clk(clk), .rst_n(rst_n_b), .col(col_b), .row(row_b), .video_on(vo_b),
    .rgb_in(rom_b), .hs(hs_b), .vs(vs_b), .rgb(rgb_b),
    .frame_tick(ft_b), .toggle_clk(tog_b)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({col_a, row_a, hs_a, vs_a, rgb_a, ft_a, tog_a} !== {10'd0, 10'd0, 1'b1, 1'b1, 12'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_a got col=%0d row=%0d hs=%b vs=%b rgb=%h ft=%b tog=%b exp 0 0 1 1 000 0 0",
               col_a, row_a, hs_a, vs_a, rgb_a, ft_a, tog_a);
    end
    checks++;
    if ({col_b, row_b, hs_b, vs_b, rgb_b, ft_b, tog_b} !== {10'd0, 10'd0, 1'b1, 1'b1, 12'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_b got col=%0d row=%0d hs=%b vs=%b rgb=%h ft=%b tog=%b exp 0 0 1 1 000 0 0",
               col_b, row_b, hs_b, vs_b, rgb_b, ft_b, tog_b);
    end
    rst_n_a = 1'b1;
  endtask

  task automatic test_hsync();
    int first, width, i;
    first = -1;
    for (i = 0; i < 4 * HT * CDA; i++) begin
      @(negedge clk);
      if (hs_a === 1'b0) begin first = na; break; end
    end
    checks++;
    if (first != (HV + HF + 1) * CDA) begin
      failures++;
      $display("FAIL hs_fall got n=%0d exp n=%0d", first, (HV + HF + 1) * CDA);
    end
    width = 0;
    for (i = 0; i < 4 * HT * CDA && hs_a === 1'b0; i++) begin
      width++;
      @(negedge clk);
    end
    checks++;
    if (width != HSY * CDA) begin
      failures++;
      $display("FAIL hs_width got %0d exp %0d", width, HSY * CDA);
    end
    for (i = 0; i < 4 * HT * CDA && hs_a !== 1'b0; i++) @(negedge clk);
    checks++;
    if (na - first != HT * CDA) begin
      failures++;
      $display("FAIL hs_period got %0d exp %0d", na - first, HT * CDA);
    end
  endtask

  task automatic test_vsync();
    int first, width, i;
    first = -1;
    for (i = 0; i < 2 * FR * CDA; i++) begin
      @(negedge clk);
      if (vs_a === 1'b0) begin first = na; break; end
    end
    checks++;
    if (first != ((VV + VF) * HT + 1) * CDA) begin
      failures++;
      $display("FAIL vs_fall got n=%0d exp n=%0d", first, ((VV + VF) * HT + 1) * CDA);
    end
    width = 0;
    for (i = 0; i < 2 * FR * CDA && vs_a === 1'b0; i++) begin
      width++;
      @(negedge clk);
    end
    checks++;
    if (width != VSY * HT * CDA) begin
      failures++;
      $display("FAIL vs_width got %0d exp %0d", width, VSY * HT * CDA);
    end
  endtask

  task automatic test_rgb_point();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FR * CDA; i++) begin
      @(negedge clk);
      if (col_a == 10'd6 && row_a == 10'd2) begin found = 1'b1; break; end
    end
    checks++;
    if (!found || rgb_a !== 12'h205) begin
      failures++;
      $display("FAIL rgb_point found=%0d got %h exp 205", found, rgb_a);
    end
  endtask

  task automatic test_scan_model();
    int p;
    for (int i = 0; i < 2 * FR * CDA; i++) begin
      @(negedge clk);
      p = na / CDA;
      checks++;
      if (col_a !== 10'(p % HT) || row_a !== 10'((p / HT) % VT)) begin
        failures++;
        $display("FAIL scan_coord n=%0d got %0d,%0d exp %0d,%0d", na, col_a, row_a, p % HT, (p / HT) % VT);
      end
      checks++;
      if (vo_a !== ((p % HT) < HV && ((p / HT) % VT) < VV)) begin
        failures++;
        $display("FAIL scan_video_on n=%0d got %b", na, vo_a);
      end
      checks++;
      if (hs_a !== exp_hs(p) || vs_a !== exp_vs(p)) begin
        failures++;
        $display("FAIL scan_sync n=%0d got hs=%b vs=%b exp hs=%b vs=%b", na, hs_a, vs_a, exp_hs(p), exp_vs(p));
      end
      checks++;
      if (rgb_a !== exp_rgb(p, 1'b0, 0)) begin
        failures++;
        $display("FAIL scan_rgb n=%0d got %h exp %h", na, rgb_a, exp_rgb(p, 1'b0, 0));
      end
      checks++;
      if (ft_a !== exp_ft(na, CDA) || tog_a !== 1'(((p / FR) / ANA) % 2)) begin
        failures++;
        $display("FAIL scan_tick n=%0d got ft=%b tog=%b", na, ft_a, tog_a);
      end
    end
  endtask

  task automatic test_frame_tick();
    int cnt, last, prev_ft;
    cnt = 0; last = -1; prev_ft = 0;
    for (int i = 0; i < 3 * FR * CDA; i++) begin
      @(negedge clk);
      if (ft_a === 1'b1) begin
        cnt++;
        checks++;
        if (prev_ft != 0) begin
          failures++;
          $display("FAIL tick_width got >1 clk at n=%0d exp 1 clk", na);
        end
        if (last >= 0) begin
          checks++;
          if (na - last != FR * CDA) begin
            failures++;
            $display("FAIL tick_spacing got %0d exp %0d", na - last, FR * CDA);
          end
        end
        last = na;
      end
      prev_ft = (ft_a === 1'b1);
    end
    checks++;
    if (cnt != 3) begin
      failures++;
      $display("FAIL tick_count got %0d exp 3", cnt);
    end
  endtask

  task automatic test_mid_reset();
    int tc, tr, p;
    bit found;
    tc = $urandom_range(HT - 1, 1);
    tr = $urandom_range(VT - 1, 1);
    found = 1'b0;
    for (int i = 0; i < 2 * FR * CDA; i++) begin
      @(negedge clk);
      if (col_a == 10'(tc) && row_a == 10'(tr)) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_reset_reach got none exp col=%0d row=%0d", tc, tr);
    end
    @(posedge clk);
    #1 rst_n_a = 1'b0;
    #1;
    checks++;
    if ({col_a, row_a, hs_a, vs_a, rgb_a, ft_a, tog_a} !== {10'd0, 10'd0, 1'b1, 1'b1, 12'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_vals got col=%0d row=%0d hs=%b vs=%b rgb=%h ft=%b tog=%b exp 0 0 1 1 000 0 0",
               col_a, row_a, hs_a, vs_a, rgb_a, ft_a, tog_a);
    end
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (col_a !== ((k == 4) ? 10'd1 : 10'd0)) begin
        failures++;
        $display("FAIL mid_reset_restart edge=%0d got col=%0d exp %0d", k, col_a, (k == 4) ? 1 : 0);
      end
    end
    for (int i = 0; i < 3 * HT * CDA; i++) begin
      @(negedge clk);
      p = na / CDA;
      checks++;
      if (col_a !== 10'(p % HT) || hs_a !== exp_hs(p) || rgb_a !== exp_rgb(p, 1'b0, 0)) begin
        failures++;
        $display("FAIL mid_reset_resume n=%0d got col=%0d hs=%b rgb=%h exp %0d %b %h",
                 na, col_a, hs_a, rgb_a, p % HT, exp_hs(p), exp_rgb(p, 1'b0, 0));
      end
    end
  endtask

  task automatic test_toggle();
    int k;
    bit want;
    k = 0;
    checks++;
    if (tog_a !== 1'b0) begin
      failures++;
      $display("FAIL toggle_start got %b exp 0", tog_a);
    end
    for (int i = 0; i < 5 * FR * CDA && k < 4; i++) begin
      @(negedge clk);
      if (ft_a === 1'b1) begin
        k++;
        want = (k / 2) % 2;
        @(negedge clk);
        checks++;
        if (tog_a !== want) begin
          failures++;
          $display("FAIL toggle_after_tick%0d got %b exp %b", k, tog_a, want);
        end
      end
    end
    checks++;
    if (k != 4) begin
      failures++;
      $display("FAIL toggle_ticks got %0d exp 4", k);
    end
  endtask

  task automatic test_clkdiv2_rom();
    int p;
    seed_b = int'($urandom_range(4095, 0));
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1;
    for (int i = 0; i < 2 * FR * CDB + 8; i++) begin
      @(negedge clk);
      p = nb / CDB;
      checks++;
      if (col_b !== 10'(p % HT) || row_b !== 10'((p / HT) % VT) ||
          vo_b !== ((p % HT) < HV && ((p / HT) % VT) < VV)) begin
        failures++;
        $display("FAIL div2_coord n=%0d got %0d,%0d vo=%b exp %0d,%0d", nb, col_b, row_b, vo_b, p % HT, (p / HT) % VT);
      end
      checks++;
      if (rgb_b !== exp_rgb(p, 1'b1, seed_b) || hs_b !== exp_hs(p) || vs_b !== exp_vs(p)) begin
        failures++;
        $display("FAIL div2_pixel n=%0d got rgb=%h hs=%b vs=%b exp %h %b %b",
                 nb, rgb_b, hs_b, vs_b, exp_rgb(p, 1'b1, seed_b), exp_hs(p), exp_vs(p));
      end
      checks++;
      if (ft_b !== exp_ft(nb, CDB) || tog_b !== 1'(((p / FR) / ANB) % 2)) begin
        failures++;
        $display("FAIL div2_tick n=%0d got ft=%b tog=%b", nb, ft_b, tog_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_vsync();
    test_rgb_point();
    test_scan_model();
    test_frame_tick();
    test_mid_reset();
    test_toggle();
    test_clkdiv2_rom();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
